tdc_readout: RTL and testbench

TDC_READOUT -- requirements
Module: tdc_readout

---
 rtl/tdc_pkg.sv | 39 +++
 rtl/tdc_therm_encoder.sv | 34 +++
 rtl/tdc_readout.sv | 164 ++++++++++++++++
 tb/tb_tdc_readout.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC readout: FSM states, parameter defaults
// and the bit layout of the result byte.
package tdc_pkg;

    localparam int TAPS_DEF     = 32;
    localparam int AVG_LOG2_DEF = 2;
    localparam int TIMEOUT_DEF  = 255;

    // Width of one encoded sample; holds 0..TAPS for up to 63 taps.
    localparam int CODE_W = 6;

    // Result byte layout: {overflow, timeout, avg_code[5:0]}
    localparam int RES_OVF_BIT  = 7;
    localparam int RES_TMO_BIT  = 6;
    localparam int RES_CODE_MSB = 5;
    localparam int RES_CODE_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_ENCODE,
        ST_ACCUM,
        ST_RELEASE,
        ST_OUTPUT
    } state_t;

    function automatic logic [7:0] pack_result(input logic ovf,
                                               input logic tmo,
                                               input logic [CODE_W-1:0] code);
        logic [7:0] r;
        r = '0;
        r[RES_OVF_BIT] = ovf;
        r[RES_TMO_BIT] = tmo;
        r[RES_CODE_MSB:RES_CODE_LSB] = code;
        return r;
    endfunction

endpackage

// File: rtl/tdc_therm_encoder.sv
// Thermometer-to-binary encoder for the vernier line. A 3-input majority
// vote per tap removes single-tap bubbles, then the corrected taps are
// counted. The line is treated as set below tap 0 and clear above the top.
module tdc_therm_encoder
    import tdc_pkg::*;
#(
    parameter int TAPS = TAPS_DEF
) (
    input  logic [TAPS-1:0]   therm,
    output logic [CODE_W-1:0] code
);

    logic [TAPS+1:0] ext;
    logic [TAPS-1:0] fixed;

    assign ext = {1'b0, therm, 1'b1};

    // majority of (tap below, tap, tap above) for every tap
    always_comb begin
        fixed = '0;
        for (int i = 0; i < TAPS; i++) begin
            fixed[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    // population count of the corrected taps
    always_comb begin
        code = '0;
        for (int i = 0; i < TAPS; i++) begin
            code = code + CODE_W'(fixed[i]);
        end
    end

endmodule

// File: rtl/tdc_readout.sv
// TDC readout controller: arms the vernier line, waits for the stop flag,
// captures and encodes the thermometer code, and averages 2**AVG_LOG2
// samples into one result byte handed out with a valid/ready handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | line cleared, waiting for start_i
//   WAIT     | line armed, waiting for stop edge or timeout count-down
//   CAPTURE  | register therm_i
//   ENCODE   | bubble-correct and count taps, flag overflow
//   ACCUM    | add sample to sum, decide next sample or output
//   RELEASE  | line disarmed, >=2 cycles and until synced stop is low
//   OUTPUT   | result_o held valid until accepted
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int TAPS     = TAPS_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            meas_done_i,
    input  logic [TAPS-1:0] therm_i,
    output logic            arm_o,
    output logic [7:0]      result_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic            busy_o
);

    localparam int SUM_W = CODE_W + AVG_LOG2;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD   = TMO_W'(TIMEOUT);
    localparam logic [AVG_LOG2:0] SAMPLES_M1 = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    state_t              state;
    logic                sync1, sync2, sync_d;
    logic                done_s, cap_evt;
    logic [TAPS-1:0]     therm_q;
    logic [CODE_W-1:0]   enc_code, code_q, avg;
    logic [SUM_W-1:0]    sum, sum_nxt;
    logic [AVG_LOG2:0]   samp_left;
    logic [TMO_W-1:0]    wait_cnt;
    logic                rel_cnt;
    logic                ovf, tmo;

    tdc_therm_encoder #(.TAPS(TAPS)) u_enc (
        .therm (therm_q),
        .code  (enc_code)
    );

    assign done_s  = sync2;
    assign cap_evt = sync2 & ~sync_d;
    assign sum_nxt = sum + SUM_W'(code_q);
    assign avg     = CODE_W'(sum_nxt >> AVG_LOG2);

    // two-flop synchronizer for the stop flag plus a delayed copy for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= meas_done_i;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    // measurement sequencer; outputs are set on the transitions into each state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            arm_o          <= 1'b0;
            busy_o         <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            sum            <= '0;
            samp_left      <= SAMPLES_M1;
            wait_cnt       <= TMO_LOAD;
            rel_cnt        <= 1'b0;
            ovf            <= 1'b0;
            tmo            <= 1'b0;
            therm_q        <= '0;
            code_q         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i && !result_valid_o) begin
                        state    <= ST_WAIT;
                        arm_o    <= 1'b1;
                        busy_o   <= 1'b1;
                        wait_cnt <= TMO_LOAD;
                    end
                end
                ST_WAIT: begin
                    // a stop edge takes priority over an expiring count
                    if (cap_evt) begin
                        state <= ST_CAPTURE;
                    end else if (wait_cnt == '0) begin
                        state  <= ST_ACCUM;
                        code_q <= '0;
                        tmo    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    therm_q <= therm_i;
                    state   <= ST_ENCODE;
                end
                ST_ENCODE: begin
                    code_q <= enc_code;
                    if (enc_code == CODE_W'(TAPS)) begin
                        ovf <= 1'b1;
                    end
                    state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    sum   <= sum_nxt;
                    arm_o <= 1'b0;
                    if (samp_left == '0) begin
                        state          <= ST_OUTPUT;
                        result_o       <= pack_result(ovf, tmo, avg);
                        result_valid_o <= 1'b1;
                    end else begin
                        samp_left <= samp_left - 1'b1;
                        rel_cnt   <= 1'b1;
                        state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt) begin
                        rel_cnt <= 1'b0;
                    end else if (!done_s) begin
                        state    <= ST_WAIT;
                        arm_o    <= 1'b1;
                        wait_cnt <= TMO_LOAD;
                    end
                end
                ST_OUTPUT: begin
                    if (result_ready_i) begin
                        state          <= ST_IDLE;
                        result_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                        sum            <= '0;
                        samp_left      <= SAMPLES_M1;
                        ovf            <= 1'b0;
                        tmo            <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    arm_o          <= 1'b0;
                    busy_o         <= 1'b0;
                    result_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_readout.sv
// Bench for tdc_readout: a behavioural delay line answers arm_o with a stop
// flag and a per-sample thermometer code; expected result bytes are queued
// at start and compared when the DUT hands a result over.
module tb_tdc_readout;

    localparam int TAPS     = 32;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 255;
    localparam int NSAMP    = 1 << AVG_LOG2;
    localparam int LEN_HIT  = 6;            // WAIT(1+2 sync) + CAPTURE + ENCODE + ACCUM
    localparam int LEN_TMO  = TIMEOUT + 2;  // TIMEOUT+1 WAIT cycles + ACCUM

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_i;
    logic            meas_done_i;
    logic [TAPS-1:0] therm_i;
    logic            arm_o;
    logic [7:0]      result_o;
    logic            result_valid_o;
    logic            result_ready_i;
    logic            busy_o;

    int              n_chk  = 0;
    int              n_fail = 0;
    int              n_acc  = 0;
    int              pulses = 0;
    int              high_len;
    logic            arm_prev;
    bit              stop_en;
    logic [7:0]      exp_q[$];
    int              len_q[$];
    logic [TAPS-1:0] therm_tab[NSAMP];

    always #5 clk = ~clk;

    tdc_readout #(
        .TAPS     (TAPS),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .meas_done_i    (meas_done_i),
        .therm_i        (therm_i),
        .arm_o          (arm_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // delay line: on arm rise present the next code and (optionally) the stop flag
    initial begin
        arm_prev    = 1'b0;
        high_len    = 0;
        meas_done_i = 1'b0;
        therm_i     = '0;
        forever begin
            @(negedge clk);
            if (arm_o === 1'b1) begin
                if (!arm_prev) begin
                    therm_i  = therm_tab[pulses % NSAMP];
                    pulses++;
                    high_len = 0;
                    if (stop_en) meas_done_i = 1'b1;
                end
                high_len++;
            end else begin
                if (arm_prev) len_q.push_back(high_len);
                meas_done_i = 1'b0;
            end
            arm_prev = (arm_o === 1'b1);
        end
    end

    // result monitor: a handshake pops the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (result_valid_o === 1'b1 && result_ready_i === 1'b1) begin
                n_acc++;
                check_eq("result_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("result_o", result_o, exp_q.pop_front());
            end
        end
    end

    task automatic start_pulse();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check_eq("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 4000 && result_valid_o !== 1'b1; i++) @(negedge clk);
        check_eq("valid_seen", result_valid_o, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy_o !== 1'b0; i++) @(negedge clk);
        check_eq("idle_after_accept", busy_o, 0);
    endtask

    task automatic run_meas(input logic [TAPS-1:0] t0, input logic [TAPS-1:0] t1,
                            input logic [TAPS-1:0] t2, input logic [TAPS-1:0] t3,
                            input bit stop, input logic [7:0] exp, input int exp_len);
        int acc_before;
        therm_tab = '{t0, t1, t2, t3};
        stop_en   = stop;
        pulses    = 0;
        len_q.delete();
        acc_before = n_acc;
        exp_q.push_back(exp);
        start_pulse();
        wait_valid();
        wait_idle();
        @(negedge clk);
        check_eq("arm_pulses", pulses, NSAMP);
        check_eq("arm_len_count", len_q.size(), NSAMP);
        foreach (len_q[k]) check_eq("arm_high_len", len_q[k], exp_len);
        check_eq("valid_once", n_acc, acc_before + 1);
        check_eq("valid_dropped", result_valid_o, 0);
    endtask

    initial begin
        int acc_before;
        rst_n          = 1'b0;
        start_i        = 1'b0;
        result_ready_i = 1'b1;
        stop_en        = 1'b1;
        therm_tab      = '{default: '0};
        repeat (3) @(negedge clk);
        check_eq("rst_arm", arm_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_valid", result_valid_o, 0);
        check_eq("rst_result", result_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_meas(32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 8'h10, LEN_HIT);
        run_meas(32'h0001FEFF, 32'h0001FEFF, 32'h0001FEFF, 32'h0001FEFF, 1'b1, 8'h11, LEN_HIT);
        run_meas(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 8'hA0, LEN_HIT);
        run_meas(32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 8'h40, LEN_TMO);
        // codes 3,5,8,1: sum 17, average truncates to 4
        run_meas(32'h00000007, 32'h0000001F, 32'h000000FF, 32'h00000001, 1'b1, 8'h04, LEN_HIT);

        // consumer stalls: result holds, start is ignored
        result_ready_i = 1'b0;
        therm_tab = '{default: 32'h0000FFFF};
        stop_en = 1'b1;
        pulses = 0;
        exp_q.push_back(8'h10);
        start_pulse();
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_result", result_o, 8'h10);
            check_eq("hold_valid", result_valid_o, 1);
            start_i = (i == 3);
            @(negedge clk);
        end
        start_i = 1'b0;
        acc_before = n_acc;
        result_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("hold_accept", n_acc, acc_before + 1);
        check_eq("hold_idle", busy_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("start_ignored_arm", arm_o, 0);
        end

        // reset during WAIT of the second sample, then a clean measurement
        therm_tab = '{default: 32'h0000FFFF};
        stop_en = 1'b1;
        pulses = 0;
        start_pulse();
        for (int i = 0; i < 200 && pulses < 2; i++) @(negedge clk);
        check_eq("reached_sample2", 32'(pulses >= 2), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_arm", arm_o, 0);
        check_eq("midrst_busy", busy_o, 0);
        check_eq("midrst_valid", result_valid_o, 0);
        check_eq("midrst_result", result_o, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_meas(32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 8'h10, LEN_HIT);

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
